// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional illegal-opcode checking is enabled by defining ALU_OPCHK_EN.
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [DATA_W-1:0] src1_0_i,
  input  logic [DATA_W-1:0] src2_0_i,
  input  logic [CTRL_W-1:0] ctrl0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] src1_1_i,
  input  logic [DATA_W-1:0] src2_1_i,
  input  logic [CTRL_W-1:0] ctrl1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam int LAT_CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_CW-1:0] LAT_INIT = LAT_CW'(ALU_LAT - 1);

  state_t            state_q, state_nxt;
  logic [LAT_CW-1:0] lat_cnt;
  logic              last_gnt;
  logic              served;
  logic              exec_first;
  logic              any_req, win, grant_en, cap_en;
  logic [DATA_W-1:0] win_src1, win_src2;
  logic [CTRL_W-1:0] win_ctrl;

  assign any_req  = req0_i | req1_i;
  // On a tie the requester that was not served last wins; otherwise the sole requester.
  assign win      = (req0_i && req1_i) ? ~last_gnt : req1_i;
  assign grant_en = ((state_q == IDLE) || (state_q == DONE)) && any_req;
  assign cap_en   = (state_q == EXEC) && (lat_cnt == '0);
  assign win_src1 = win ? src1_1_i : src1_0_i;
  assign win_src2 = win ? src2_1_i : src2_0_i;
  assign win_ctrl = win ? ctrl1_i : ctrl0_i;

`ifdef ALU_OPCHK_EN
  function automatic logic op_legal(input logic [CTRL_W-1:0] op);
    return (op == CTRL_W'(4'b0000)) || (op == CTRL_W'(4'b0001)) ||
           (op == CTRL_W'(4'b0010)) || (op == CTRL_W'(4'b0110)) ||
           (op == CTRL_W'(4'b0111));
  endfunction

  logic win_legal;
  logic err_pend;
  logic err_q;

  assign win_legal = op_legal(win_ctrl);
  assign err_o     = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_gnt   <= 1'b1;
      served     <= 1'b0;
      exec_first <= 1'b0;
      lat_cnt    <= '0;
      alu_src1_o <= '0;
      alu_src2_o <= '0;
      alu_ctrl_o <= '0;
      result_o   <= '0;
      zero_o     <= 1'b0;
`ifdef ALU_OPCHK_EN
      err_pend   <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      exec_first <= grant_en;
      if (grant_en) begin
        last_gnt <= win;
        served   <= win;
`ifdef ALU_OPCHK_EN
        // Illegal ops still take a grant slot but never reach the ALU.
        err_pend <= ~win_legal;
        if (win_legal) begin
          lat_cnt    <= LAT_INIT;
          alu_src1_o <= win_src1;
          alu_src2_o <= win_src2;
          alu_ctrl_o <= win_ctrl;
        end else begin
          lat_cnt <= '0;
        end
`else
        lat_cnt    <= LAT_INIT;
        alu_src1_o <= win_src1;
        alu_src2_o <= win_src2;
        alu_ctrl_o <= win_ctrl;
`endif
      end else if ((state_q == EXEC) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_CW'(1);
      end
      if (cap_en) begin
`ifdef ALU_OPCHK_EN
        result_o <= err_pend ? '0 : alu_result_i;
        zero_o   <= err_pend ? 1'b0 : alu_zero_i;
        err_q    <= err_pend;
`else
        result_o <= alu_result_i;
        zero_o   <= alu_zero_i;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    if (lat_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = any_req ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == EXEC) || (state_q == DONE);
    gnt0_o  = (state_q == EXEC) && exec_first && !served;
    gnt1_o  = (state_q == EXEC) && exec_first && served;
    done0_o = (state_q == DONE) && !served;
    done1_o = (state_q == DONE) && served;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a one-cycle and a three-cycle-latency instance,
// each driven by a small combinational ALU.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Instance A: ALU_LAT = 1
  logic        req0, req1;
  logic [31:0] s10, s20, s11, s21;
  logic [3:0]  c0, c1;
  logic        gnt0, gnt1, done0, done1, zero, err, busy, a_zero;
  logic [31:0] result, a_src1, a_src2, a_res;
  logic [3:0]  a_ctrl;

  always_comb a_res = alu_fn(a_src1, a_src2, a_ctrl);
  assign a_zero = (a_res == 32'd0);

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .ALU_LAT(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .src1_0_i(s10), .src2_0_i(s20), .ctrl0_i(c0),
    .req1_i(req1), .src1_1_i(s11), .src2_1_i(s21), .ctrl1_i(c1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
    .result_o(result), .zero_o(zero), .err_o(err), .busy_o(busy),
    .alu_src1_o(a_src1), .alu_src2_o(a_src2), .alu_ctrl_o(a_ctrl),
    .alu_result_i(a_res), .alu_zero_i(a_zero)
  );

  // Instance B: ALU_LAT = 3
  logic        req0_b, req1_b;
  logic [31:0] s10_b, s20_b, s11_b, s21_b;
  logic [3:0]  c0_b, c1_b;
  logic        gnt0_b, gnt1_b, done0_b, done1_b, zero_b, err_b, busy_b, a_zero_b;
  logic [31:0] result_b, a_src1_b, a_src2_b, a_res_b;
  logic [3:0]  a_ctrl_b;

  always_comb a_res_b = alu_fn(a_src1_b, a_src2_b, a_ctrl_b);
  assign a_zero_b = (a_res_b == 32'd0);

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .ALU_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0_b), .src1_0_i(s10_b), .src2_0_i(s20_b), .ctrl0_i(c0_b),
    .req1_i(req1_b), .src1_1_i(s11_b), .src2_1_i(s21_b), .ctrl1_i(c1_b),
    .gnt0_o(gnt0_b), .gnt1_o(gnt1_b), .done0_o(done0_b), .done1_o(done1_b),
    .result_o(result_b), .zero_o(zero_b), .err_o(err_b), .busy_o(busy_b),
    .alu_src1_o(a_src1_b), .alu_src2_o(a_src2_b), .alu_ctrl_o(a_ctrl_b),
    .alu_result_i(a_res_b), .alu_zero_i(a_zero_b)
  );

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if ({gnt0, gnt1, done0, done1} !== 4'b0) $display("FAIL rst_pulses got %b exp 0000", {gnt0, gnt1, done0, done1}); else pass_cnt++;
    chk_cnt++; if (result !== 32'd0) $display("FAIL rst_result got %h exp 0", result); else pass_cnt++;
    chk_cnt++; if ({zero, err} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {zero, err}); else pass_cnt++;
    chk_cnt++; if ({a_src1, a_src2, a_ctrl} !== 68'd0) $display("FAIL rst_alu_ports got %h exp 0", {a_src1, a_src2, a_ctrl}); else pass_cnt++;
    chk_cnt++; if ({busy_b, gnt0_b, gnt1_b, done0_b, done1_b} !== 5'b0) $display("FAIL rst_b_ctrl got %b exp 00000", {busy_b, gnt0_b, gnt1_b, done0_b, done1_b}); else pass_cnt++;
  endtask

  task automatic test_single_and();
    req0 = 1'b1; s10 = 32'hF0F000FF; s20 = 32'h0FF00F0F; c0 = 4'b0000;
    @(negedge clk);
    chk_cnt++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL t1_gnt got %b exp 10", {gnt0, gnt1}); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL t1_busy got %b exp 1", busy); else pass_cnt++;
    chk_cnt++; if ({a_src1, a_src2} !== {32'hF0F000FF, 32'h0FF00F0F}) $display("FAIL t1_alu_src got %h exp F0F000FF0FF00F0F", {a_src1, a_src2}); else pass_cnt++;
    chk_cnt++; if (done0 !== 1'b0) $display("FAIL t1_early_done got %b exp 0", done0); else pass_cnt++;
    req0 = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({done0, done1, gnt0} !== 3'b100) $display("FAIL t1_done got %b exp 100", {done0, done1, gnt0}); else pass_cnt++;
    chk_cnt++; if (result !== 32'h00F0000F) $display("FAIL t1_result got %h exp 00F0000F", result); else pass_cnt++;
    chk_cnt++; if (zero !== 1'b0) $display("FAIL t1_zero got %b exp 0", zero); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({busy, done0} !== 2'b00) $display("FAIL t1_idle got %b exp 00", {busy, done0}); else pass_cnt++;
    chk_cnt++; if (result !== 32'h00F0000F) $display("FAIL t1_hold got %h exp 00F0000F", result); else pass_cnt++;
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1'b1; s10 = 32'd5; s20 = 32'd5; c0 = 4'b0110;
    req1 = 1'b1; s11 = 32'd3; s21 = 32'd4; c1 = 4'b0010;
    @(negedge clk);
    chk_cnt++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL t2_gnt0 got %b exp 10", {gnt0, gnt1}); else pass_cnt++;
    chk_cnt++; if (a_ctrl !== 4'b0110) $display("FAIL t2_ctrl0 got %b exp 0110", a_ctrl); else pass_cnt++;
    req0 = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({done0, done1} !== 2'b10) $display("FAIL t2_done0 got %b exp 10", {done0, done1}); else pass_cnt++;
    chk_cnt++; if ({result, zero} !== {32'd0, 1'b1}) $display("FAIL t2_res0 got %h/%b exp 0/1", result, zero); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL t2_gnt1 got %b exp 01", {gnt0, gnt1}); else pass_cnt++;
    chk_cnt++; if (a_ctrl !== 4'b0010) $display("FAIL t2_ctrl1 got %b exp 0010", a_ctrl); else pass_cnt++;
    req1 = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({done0, done1} !== 2'b01) $display("FAIL t2_done1 got %b exp 01", {done0, done1}); else pass_cnt++;
    chk_cnt++; if ({result, zero} !== {32'd7, 1'b0}) $display("FAIL t2_res1 got %h/%b exp 7/0", result, zero); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL t2_idle got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ng;
    int gid[6];
    int gcyc[6];
    ng = 0;
    for (int k = 0; k < 6; k++) begin gid[k] = -1; gcyc[k] = -100; end
    do_reset();
    s10 = 32'h0000FFFF; s20 = 32'h000000FF; c0 = 4'b0000;
    s11 = 32'hFFFFFFFF; s21 = 32'd1;        c1 = 4'b0111;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt0 && ng < 6) begin gid[ng] = 0; gcyc[ng] = c; ng++; end
      if (gnt1 && ng < 6) begin gid[ng] = 1; gcyc[ng] = c; ng++; end
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (done0) req0 = 1'b1;
      if (done1) req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk_cnt++; if (ng !== 6) $display("FAIL t3_grant_count got %0d exp 6", ng); else pass_cnt++;
    chk_cnt++; if (gcyc[0] !== 0) $display("FAIL t3_first_gnt_cycle got %0d exp 0", gcyc[0]); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      chk_cnt++; if (gid[k] !== k % 2) $display("FAIL t3_order[%0d] got %0d exp %0d", k, gid[k], k % 2); else pass_cnt++;
    end
    for (int k = 1; k < 6; k++) begin
      chk_cnt++; if (gcyc[k] - gcyc[k-1] !== 2) $display("FAIL t3_spacing[%0d] got %0d exp 2", k, gcyc[k] - gcyc[k-1]); else pass_cnt++;
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  task automatic test_latency3();
    do_reset();
    req1_b = 1'b1; s11_b = 32'h0000FFFF; s21_b = 32'hFFFF0000; c1_b = 4'b0001;
    req0_b = 1'b0; s10_b = 32'd0; s20_b = 32'd0; c0_b = 4'b0000;
    @(negedge clk);
    chk_cnt++; if ({gnt0_b, gnt1_b} !== 2'b01) $display("FAIL t4_gnt1 got %b exp 01", {gnt0_b, gnt1_b}); else pass_cnt++;
    chk_cnt++; if ({a_src1_b, a_src2_b, a_ctrl_b} !== {32'h0000FFFF, 32'hFFFF0000, 4'b0001}) $display("FAIL t4_ports_c1 got %h exp 0000FFFFFFFF00001", {a_src1_b, a_src2_b, a_ctrl_b}); else pass_cnt++;
    req1_b = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({busy_b, gnt1_b, done1_b} !== 3'b100) $display("FAIL t4_c2 got %b exp 100", {busy_b, gnt1_b, done1_b}); else pass_cnt++;
    chk_cnt++; if (a_src1_b !== 32'h0000FFFF) $display("FAIL t4_hold_c2 got %h exp 0000FFFF", a_src1_b); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({busy_b, done1_b} !== 2'b10) $display("FAIL t4_c3 got %b exp 10", {busy_b, done1_b}); else pass_cnt++;
    chk_cnt++; if (a_src2_b !== 32'hFFFF0000) $display("FAIL t4_hold_c3 got %h exp FFFF0000", a_src2_b); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({done0_b, done1_b} !== 2'b01) $display("FAIL t4_done1 got %b exp 01", {done0_b, done1_b}); else pass_cnt++;
    chk_cnt++; if ({result_b, zero_b} !== {32'hFFFFFFFF, 1'b0}) $display("FAIL t4_result got %h/%b exp FFFFFFFF/0", result_b, zero_b); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_exec();
    req0 = 1'b1; s10 = 32'd3; s20 = 32'd4; c0 = 4'b0010;
    req1 = 1'b1; s11 = 32'd1; s21 = 32'd1; c1 = 4'b0000;
    @(negedge clk);
    chk_cnt++; if (gnt0 !== 1'b1) $display("FAIL t5_pre_gnt0 got %b exp 1", gnt0); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({busy, gnt0, gnt1, done0, done1} !== 5'b0) $display("FAIL t5_rst_ctrl got %b exp 00000", {busy, gnt0, gnt1, done0, done1}); else pass_cnt++;
    chk_cnt++; if ({a_src1, a_ctrl} !== 36'd0) $display("FAIL t5_rst_ports got %h exp 0", {a_src1, a_ctrl}); else pass_cnt++;
    chk_cnt++; if ({result, zero, err} !== 34'd0) $display("FAIL t5_rst_result got %h exp 0", {result, zero, err}); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL t5_regnt got %b exp 10", {gnt0, gnt1}); else pass_cnt++;
    req0 = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({done0, result} !== {1'b1, 32'd7}) $display("FAIL t5_done0 got %b/%h exp 1/7", done0, result); else pass_cnt++;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal_op();
    req0 = 1'b1; s10 = 32'h12345678; s20 = 32'd1; c0 = 4'b1111;
    @(negedge clk);
    chk_cnt++; if (gnt0 !== 1'b1) $display("FAIL t6_gnt0 got %b exp 1", gnt0); else pass_cnt++;
    req0 = 1'b0;
`ifdef ALU_OPCHK_EN
    chk_cnt++; if ({a_src1, a_ctrl} !== {32'd3, 4'b0010}) $display("FAIL t6_ports_kept got %h exp 000000032", {a_src1, a_ctrl}); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({done0, err} !== 2'b11) $display("FAIL t6_done_err got %b exp 11", {done0, err}); else pass_cnt++;
    chk_cnt++; if ({result, zero} !== {32'd0, 1'b0}) $display("FAIL t6_result got %h/%b exp 0/0", result, zero); else pass_cnt++;
`else
    chk_cnt++; if ({a_src1, a_ctrl} !== {32'h12345678, 4'b1111}) $display("FAIL t6_ports_fwd got %h exp 12345678F", {a_src1, a_ctrl}); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({done0, err} !== 2'b10) $display("FAIL t6_done_noerr got %b exp 10", {done0, err}); else pass_cnt++;
    chk_cnt++; if ({result, zero} !== {32'd0, 1'b1}) $display("FAIL t6_result got %h/%b exp 0/1", result, zero); else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0; s10 = '0; s20 = '0; s11 = '0; s21 = '0; c0 = '0; c1 = '0;
    req0_b = 1'b0; req1_b = 1'b0; s10_b = '0; s20_b = '0; s11_b = '0; s21_b = '0; c0_b = '0; c1_b = '0;
    test_reset();
    test_single_and();
    test_tie();
    test_back_to_back();
    test_latency3();
    test_reset_in_exec();
    test_illegal_op();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
